// File: rtl/lcd_sequencer.sv
// HD44780 16x2 LCD sequencer: power-up delay, 5-command init, then continuous
// refresh of 32 characters read by address from an external async-read buffer.
module lcd_sequencer #(
  parameter int unsigned PWRUP_CYC = 750000,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC    = 16,
  parameter int unsigned CMD_WAIT  = 2000,
  parameter int unsigned CLR_WAIT  = 82000
) (
  input  logic       LCD_clk,
  input  logic       LCD_rst,
  input  logic       refresh_en,
  input  logic [7:0] char_data,
  output logic [4:0] char_addr,
  output logic       init_done,
  output logic       frame_done,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       LCD_ON
);

  // Power-up counts up from the reset value; all other phases load N-1 and count down.
  localparam logic [19:0] PwrupLd = 20'(PWRUP_CYC);
  localparam logic [19:0] SetupLd = 20'(SETUP_CYC - 1);
  localparam logic [19:0] EnLd    = 20'(EN_CYC - 1);
  localparam logic [19:0] CmdLd   = 20'(CMD_WAIT - 1);
  localparam logic [19:0] ClrLd   = 20'(CLR_WAIT - 1);

  typedef enum logic [2:0] {StPwrup, StLoad, StSetup, StEnhi, StWait, StIdle} state_e;

  state_e      state_q;
  logic [19:0] cnt_q;
  logic [5:0]  step_q;
  logic [4:0]  char_addr_q;
  logic        init_done_q;
  logic        frame_done_q;
  logic [7:0]  data_q;
  logic        rs_q;
  logic        en_q;
  logic [5:0]  step_nxt;

  function automatic logic is_char(input logic [5:0] s);
    is_char = ((s >= 6'd6) && (s <= 6'd21)) || ((s >= 6'd23) && (s <= 6'd38));
  endfunction

  function automatic logic [4:0] addr_of(input logic [5:0] s);
    addr_of = (s <= 6'd21) ? 5'(s - 6'd6) : 5'(s - 6'd7);
  endfunction

  function automatic logic [7:0] cmd_of(input logic [5:0] s);
    case (s)
      6'd0, 6'd1: cmd_of = 8'h38;
      6'd2:       cmd_of = 8'h0C;
      6'd3:       cmd_of = 8'h01;
      6'd4:       cmd_of = 8'h06;
      6'd22:      cmd_of = 8'hC0;
      default:    cmd_of = 8'h80;
    endcase
  endfunction

  // Step 38 wraps back to the line-1 address command, skipping the init steps.
  assign step_nxt = (step_q == 6'd38) ? 6'd5 : step_q + 6'd1;

  always_ff @(posedge LCD_clk or posedge LCD_rst) begin
    if (LCD_rst) begin
      state_q      <= StPwrup;
      cnt_q        <= '0;
      step_q       <= '0;
      char_addr_q  <= '0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      data_q       <= '0;
      rs_q         <= 1'b0;
      en_q         <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        StPwrup: begin
          if (cnt_q == PwrupLd) begin
            state_q <= StLoad;
            step_q  <= '0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 20'd1;
          end
        end
        StLoad: begin
          // char_data has had the whole LOAD cycle to settle on char_addr.
          data_q  <= is_char(step_q) ? char_data : cmd_of(step_q);
          rs_q    <= is_char(step_q);
          en_q    <= 1'b0;
          cnt_q   <= SetupLd;
          state_q <= StSetup;
        end
        StSetup: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            cnt_q   <= EnLd;
            state_q <= StEnhi;
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        StEnhi: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b0;
            cnt_q   <= (step_q == 6'd3) ? ClrLd : CmdLd;
            state_q <= StWait;
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            step_q       <= step_nxt;
            frame_done_q <= (step_q == 6'd38);
            if (step_nxt == 6'd5) init_done_q <= 1'b1;
            if ((step_nxt >= 6'd5) && !refresh_en) begin
              state_q <= StIdle;
            end else begin
              if (is_char(step_nxt)) char_addr_q <= addr_of(step_nxt);
              state_q <= StLoad;
            end
          end else begin
            cnt_q <= cnt_q - 20'd1;
          end
        end
        StIdle: begin
          if (refresh_en) begin
            if (is_char(step_q)) char_addr_q <= addr_of(step_q);
            state_q <= StLoad;
          end
        end
        default: state_q <= StPwrup;
      endcase
    end
  end

  assign char_addr  = char_addr_q;
  assign init_done  = init_done_q;
  assign frame_done = frame_done_q;
  assign LCD_DATA   = data_q;
  assign LCD_RS     = rs_q;
  assign LCD_EN     = en_q;
  assign LCD_RW     = 1'b0;
  assign LCD_ON     = 1'b1;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer: write stream, timing, parking and async reset
// compared against a write-list model derived from the LCD command/frame layout.
module tb_lcd_sequencer;

  localparam int SU = 2;
  localparam int EW = 3;
  localparam int CW = 5;
  localparam int LW = 20;
  localparam int WrCyc = 1 + SU + EW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       refresh_en = 1'b1;
  logic [7:0] char_data;
  logic [4:0] char_addr;
  logic       init_done, frame_done, LCD_RS, LCD_RW, LCD_EN, LCD_ON;
  logic [7:0] LCD_DATA;

  logic [7:0] bmem [32];
  assign char_data = bmem[char_addr];

  lcd_sequencer #(
    .PWRUP_CYC(10), .SETUP_CYC(SU), .EN_CYC(EW), .CMD_WAIT(CW), .CLR_WAIT(LW)
  ) dut (
    .LCD_clk(clk), .LCD_rst(rst), .refresh_en(refresh_en), .char_data(char_data),
    .char_addr(char_addr), .init_done(init_done), .frame_done(frame_done),
    .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_ON(LCD_ON)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= -1;
    else     cyc <= cyc + 1;
  end

  int errors = 0;
  int checks = 0;

  // Monitor: one entry per EN rising edge, sampled on the falling clock edge.
  logic       en_prev = 1'b0;
  int         init_cyc = -1;
  int         bad_const = 0;
  logic [7:0] wr_data [$];
  bit         wr_rs   [$];
  int         wr_cyc  [$];
  int         wr_fall [$];
  logic [4:0] wr_addr [$];
  int         fd_cyc  [$];

  always @(negedge clk) begin
    if (LCD_RW !== 1'b0 || LCD_ON !== 1'b1) bad_const <= bad_const + 1;
    if (rst) begin
      en_prev  <= 1'b0;
      init_cyc <= -1;
      wr_data.delete(); wr_rs.delete(); wr_cyc.delete();
      wr_fall.delete(); wr_addr.delete(); fd_cyc.delete();
    end else begin
      if (LCD_EN && !en_prev) begin
        wr_data.push_back(LCD_DATA);
        wr_rs.push_back(LCD_RS);
        wr_cyc.push_back(cyc);
        wr_addr.push_back(char_addr);
      end
      if (!LCD_EN && en_prev) wr_fall.push_back(cyc);
      if (init_done && init_cyc < 0) init_cyc <= cyc;
      if (frame_done) fd_cyc.push_back(cyc);
      en_prev <= LCD_EN;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected n-th write since reset: {rs, data}. A frame is 34 writes after 5 init commands.
  function automatic logic [8:0] exp_wr(input int n);
    logic [7:0] ic [5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int p;
    if (n < 5) return {1'b0, ic[n]};
    p = (n - 5) % 34;
    if (p == 0)   return {1'b0, 8'h80};
    if (p <= 16)  return {1'b1, bmem[p-1]};
    if (p == 17)  return {1'b0, 8'hC0};
    return {1'b1, bmem[p-2]};
  endfunction

  task automatic wait_wr(input string tag, input int n, input int budget);
    int k = 0;
    while (wr_data.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(wr_data.size() >= n), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_data"}, 32'(LCD_DATA), 0);
    check({tag, "_rs"}, 32'(LCD_RS), 0);
    check({tag, "_en"}, 32'(LCD_EN), 0);
    check({tag, "_addr"}, 32'(char_addr), 0);
    check({tag, "_initdone"}, 32'(init_done), 0);
    check({tag, "_framedone"}, 32'(frame_done), 0);
  endtask

  initial begin
    int         exp_rise [40];
    logic [8:0] e;
    int         k;
    int         n;

    for (int i = 0; i < 32; i++) bmem[i] = 8'(8'h41 + i);
    repeat (3) @(negedge clk);
    check_reset_vals("rst0");
    check("rst0_rw", 32'(LCD_RW), 0);
    check("rst0_on", 32'(LCD_ON), 1);
    rst = 1'b0;

    // Full init plus one frame plus the next line-1 command, fixed buffer contents.
    exp_rise[0] = 13;
    for (int i = 1; i < 40; i++) exp_rise[i] = exp_rise[i-1] + WrCyc + ((i == 4) ? LW : CW);
    wait_wr("tmo_frame", 40, 2000);
    for (int i = 0; i < 40 && i < wr_data.size(); i++) begin
      e = exp_wr(i);
      check($sformatf("a_data%0d", i), 32'(wr_data[i]), 32'(e[7:0]));
      check($sformatf("a_rs%0d", i), 32'(wr_rs[i]), 32'(e[8]));
      check($sformatf("a_rise%0d", i), wr_cyc[i], exp_rise[i]);
      if (i < wr_fall.size()) check($sformatf("a_width%0d", i), wr_fall[i] - wr_cyc[i], EW);
    end
    check("a_init_done_cyc", init_cyc, exp_rise[5] - 1 - SU);
    check("a_fd_count", fd_cyc.size(), 1);
    check("a_fd_cyc", (fd_cyc.size() > 0) ? fd_cyc[0] : -1, exp_rise[39] - 1 - SU);

    // Async reset while EN is high on a character write.
    k = 0;
    while (!(LCD_EN && LCD_RS) && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("b_char_en_seen", 32'(LCD_EN && LCD_RS), 1);
    #2 rst = 1'b1;
    #1 check_reset_vals("b_async");
    for (int i = 0; i < 32; i++) bmem[i] = 8'($urandom);
    refresh_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Init with refresh disabled: five commands, then park.
    wait_wr("tmo_init", 5, 500);
    repeat (40) @(negedge clk);
    check("c_wr_count", wr_data.size(), 5);
    check("c_first_rise", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, 13);
    for (int i = 0; i < 5 && i < wr_data.size(); i++) begin
      e = exp_wr(i);
      check($sformatf("c_data%0d", i), 32'(wr_data[i]), 32'(e[7:0]));
      check($sformatf("c_rs%0d", i), 32'(wr_rs[i]), 32'(e[8]));
    end
    check("c_init_done", 32'(init_done), 1);
    check("c_en_idle", 32'(LCD_EN), 0);

    repeat ($urandom_range(0, 5)) @(negedge clk);
    k = cyc;
    refresh_en = 1'b1;
    wait_wr("tmo_resume0", 6, 100);
    e = exp_wr(5);
    check("c_resume_data", 32'((wr_data.size() > 5) ? wr_data[5] : 8'h00), 32'(e[7:0]));
    check("c_resume_rise", (wr_cyc.size() > 5) ? wr_cyc[5] : -1, k + 2 + SU);

    // Park after the char 7 write starts (write index 13), resume at char 8.
    wait_wr("tmo_char7", 14, 500);
    refresh_en = 1'b0;
    repeat (40 + $urandom_range(0, 10)) @(negedge clk);
    check("d_park_count", wr_data.size(), 14);
    check("d_park_en", 32'(LCD_EN), 0);
    check("d_park_addr", 32'(char_addr), 7);
    k = cyc;
    refresh_en = 1'b1;
    wait_wr("tmo_resume1", 15, 100);
    e = exp_wr(14);
    check("d_resume_rise", (wr_cyc.size() > 14) ? wr_cyc[14] : -1, k + 2 + SU);
    check("d_resume_addr", 32'((wr_addr.size() > 14) ? wr_addr[14] : 5'd0), 8);
    check("d_resume_data", 32'((wr_data.size() > 14) ? wr_data[14] : 8'h00), 32'(e[7:0]));

    wait_wr("tmo_frame2", 40, 1000);
    n = (wr_data.size() < 40) ? wr_data.size() : 40;
    for (int i = 5; i < n; i++) begin
      e = exp_wr(i);
      check($sformatf("d_data%0d", i), 32'(wr_data[i]), 32'(e[7:0]));
      check($sformatf("d_rs%0d", i), 32'(wr_rs[i]), 32'(e[8]));
    end
    check("d_fd_count", fd_cyc.size(), 1);
    check("d_fd_cyc", (fd_cyc.size() > 0) ? fd_cyc[0] : -1,
          k + 2 + SU + 25 * (WrCyc + CW) - 1 - SU);
    check("const_rw_on", bad_const, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
